// File: rtl/irq_pkg.sv
// Shared types and source indices for the interrupt controller.
package irq_pkg;

  localparam int   NUM_SRC = 2;
  localparam logic SRC_KEY = 1'b0;
  localparam logic SRC_ETH = 1'b1;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_state_e;

endpackage

// File: rtl/irq_src_latch.sv
// Per-source event capture: rising-edge detect, pending bit, payload register, sticky overflow.
module irq_src_latch #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              irq_in,
  input  logic [DATA_W-1:0] payload,
  input  logic              clr,
  output logic              pending,
  output logic [DATA_W-1:0] data,
  output logic              overflow
);

  logic in_q;
  logic evt;

  assign evt = irq_in & ~in_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q     <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      in_q <= irq_in;
      // A new event beats a same-cycle clear so it is never lost.
      if (evt)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
      if (evt && pending)
        overflow <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; it is only read once pending is set, which also loads it.
  always_ff @(posedge clk) begin
    if (evt)
      data <= payload;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: two source latches, arbiter, request/service FSM.
// Optional per-source masking input when IRQ_MASK_EN is defined.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               interrupt_key,
  input  logic               interrupt_eth,
  input  logic [DATA_W-1:0]  key_data,
  input  logic [DATA_W-1:0]  eth_data,
  input  logic               irq_en,
  input  logic               irq_ack,
  input  logic               irq_ret,
`ifdef IRQ_MASK_EN
  input  logic [NUM_SRC-1:0] irq_mask,
`endif
  output logic               irq_req,
  output logic               irq_cause,
  output logic [DATA_W-1:0]  interrupt_source_data,
  output logic               in_service,
  output logic [NUM_SRC-1:0] overflow
);

  irq_state_e         state;
  logic               rr_prio;
  logic               grant;
  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] pending_clr;
  logic [DATA_W-1:0]  src_payload [NUM_SRC];
  logic [DATA_W-1:0]  src_data    [NUM_SRC];

  assign src_in                = {interrupt_eth, interrupt_key};
  assign src_payload[SRC_KEY]  = key_data;
  assign src_payload[SRC_ETH]  = eth_data;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    irq_src_latch #(.DATA_W(DATA_W)) u_latch (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_in   (src_in[s]),
      .payload  (src_payload[s]),
      .clr      (pending_clr[s]),
      .pending  (pending[s]),
      .data     (src_data[s]),
      .overflow (overflow[s])
    );
  end

`ifdef IRQ_MASK_EN
  assign eligible = pending & ~irq_mask;
`else
  assign eligible = pending;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = SRC_KEY;
    if (eligible[SRC_KEY] && eligible[SRC_ETH])
      grant = (ARB_MODE == 1) ? rr_prio : SRC_KEY;
    else if (eligible[SRC_ETH])
      grant = SRC_ETH;
  end

  always_comb begin
    pending_clr = '0;
    if (state == IRQ_REQ && irq_ack)
      pending_clr[irq_cause] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IRQ_IDLE;
      irq_req               <= 1'b0;
      irq_cause             <= SRC_KEY;
      interrupt_source_data <= '0;
      in_service            <= 1'b0;
      rr_prio               <= SRC_KEY;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (irq_en && |eligible) begin
            irq_cause             <= grant;
            interrupt_source_data <= src_data[grant];
            irq_req               <= 1'b1;
            state                 <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (irq_ack) begin
            irq_req    <= 1'b0;
            in_service <= 1'b1;
            state      <= IRQ_SERVICE;
          end
        end
        IRQ_SERVICE: begin
          if (irq_ret) begin
            in_service <= 1'b0;
            rr_prio    <= ~irq_cause;
            state      <= IRQ_IDLE;
          end
        end
        default: begin
          irq_req    <= 1'b0;
          in_service <= 1'b0;
          state      <= IRQ_IDLE;
        end
      endcase
    end
  end

endmodule
